fir_mac_sequencer: RTL and testbench

- Control block for the FIR core. It accepts one input sample at a time and stores it in an internal circular delay line.
- For each sample it schedules TAPS multiplies through the shared 16x16 ALU and accumulates the products into a 32-bit filter output.
- It sits between the sample stream, the coefficient ROM and the `alu` instance, and owns every ALU operand and op_sel.

---
 rtl/fir_mac_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Sequencer for the FIR core: holds the sample delay line, issues one multiply
// per tap through the shared ALU and accumulates the products into a 32-bit output.
module fir_mac_sequencer #(
  parameter int unsigned TAPS    = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_sample,
  output logic [AW-1:0] coef_addr,
  input  logic [15:0]   coef_data,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic [1:0]    alu_op_sel,
  input  logic [31:0]   alu_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          busy
);

  localparam int unsigned DW    = 16;
  localparam int unsigned ACC_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;

  // Every valid-pipe stage except the output stage.
  localparam logic [ALU_LAT-1:0] LOW_MASK = ALU_LAT'((64'd1 << (ALU_LAT - 1)) - 64'd1);

  logic [1:0]         state, state_d;
  logic [AW-1:0]      wr_ptr, wr_ptr_d;
  logic [AW-1:0]      base, base_d;
  logic [AW-1:0]      tap, tap_d;
  logic [AW-1:0]      coef_addr_d;
  logic [AW-1:0]      rd_idx;
  logic [ALU_LAT-1:0] vpipe, vpipe_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic [ACC_W-1:0]   out_data_d;
  logic [DW-1:0]      alu_a_d, alu_b_d;
  logic [1:0]         op_d;
  logic               out_valid_d, in_ready_d, busy_d;
  logic               wr_en;
  logic               pending;
  logic [DW-1:0]      dly_line [TAPS];

  assign rd_idx  = base - tap;
  assign pending = (alu_op_sel == OP_MUL) || ((vpipe & LOW_MASK) != '0);

  // Next-state and next-output logic. The ROM address runs one cycle ahead of
  // the tap counter so coef_data for tap k is present while tap k is issued.
  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    base_d      = base;
    tap_d       = tap;
    coef_addr_d = '0;
    vpipe_d     = (vpipe << 1) | ALU_LAT'(alu_op_sel == OP_MUL);
    acc_d       = vpipe[ALU_LAT-1] ? (acc + alu_result) : acc;
    alu_a_d     = '0;
    alu_b_d     = '0;
    op_d        = OP_IDLE;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    wr_en       = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          wr_en       = 1'b1;
          base_d      = wr_ptr;
          wr_ptr_d    = wr_ptr + AW'(1);
          acc_d       = '0;
          tap_d       = '0;
          coef_addr_d = AW'(1);
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_a_d = dly_line[rd_idx];
        alu_b_d = coef_data;
        op_d    = OP_MUL;
        if (tap == AW'(TAPS - 1)) begin
          state_d = S_DRAIN;
        end else begin
          tap_d       = tap + AW'(1);
          coef_addr_d = coef_addr + AW'(1);
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_d;
          state_d     = S_OUT;
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      base       <= '0;
      tap        <= '0;
      coef_addr  <= '0;
      vpipe      <= '0;
      acc        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op_sel <= OP_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_ptr_d;
      base       <= base_d;
      tap        <= tap_d;
      coef_addr  <= coef_addr_d;
      vpipe      <= vpipe_d;
      acc        <= acc_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_op_sel <= op_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      in_ready   <= in_ready_d;
      busy       <= busy_d;
    end
  end

  // Circular sample history; cleared on reset so early outputs see zero history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        dly_line[i] <= '0;
      end
    end else if (wr_en) begin
      dly_line[wr_ptr] <= in_sample;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed spec scenarios plus random samples and
// coefficients checked against a convolution model of the sample history.
module tb_fir_mac_sequencer;

  localparam int unsigned TAPS    = 4;
  localparam int unsigned AW      = 2;
  localparam int unsigned ALU_LAT = 2;
  localparam int LAT    = int'(TAPS + ALU_LAT + 2);
  localparam int PERIOD = int'(TAPS + ALU_LAT + 3);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_sample = '0;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_data = '0;
  logic [15:0]   alu_a, alu_b;
  logic [1:0]    alu_op_sel;
  logic [31:0]   alu_result = '0;
  logic [31:0]   alu_p1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          busy;

  logic signed [15:0] rom [TAPS];
  logic signed [15:0] hist [$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  fir_mac_sequencer #(.TAPS(TAPS), .AW(AW), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .coef_addr(coef_addr), .coef_data(coef_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment: registered coefficient ROM and a two-stage behavioural ALU.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    coef_data <= rom[coef_addr];
    alu_p1    <= (alu_op_sel == 2'b01) ? 32'(int'($signed(alu_a)) * int'($signed(alu_b)))
                                       : 32'(alu_a) + 32'(alu_b);
    alu_result <= alu_p1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // y[n] = sum_k c[k] * x[n-k] over the most recent samples, 32-bit wrap.
  function automatic logic [31:0] model_y();
    logic [31:0] s = '0;
    for (int k = 0; k < int'(TAPS); k++) begin
      if (k < hist.size())
        s += 32'(int'(rom[k]) * int'(hist[hist.size() - 1 - k]));
    end
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    hist.delete();
    rst = 1'b1;
  endtask

  // One sample through the filter; optional backpressure with a pending input.
  task automatic send(input logic [15:0] x, input logic [31:0] exp, input int hold,
                      input logic [15:0] pend, input string tag, output int hs_c);
    int cnt;
    in_valid = 1'b1; in_sample = x; out_ready = (hold == 0);
    cnt = 0;
    while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    hs_c = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 40) begin @(negedge clk); cnt++; end
    chk({tag, "_lat"}, 32'(cnt), 32'(LAT));
    chk({tag, "_data"}, out_data, exp);
    if (hold > 0) begin
      in_valid = 1'b1; in_sample = pend;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_data"}, out_data, exp);
        chk({tag, "_hold_ir"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int hs0, hs1, dummy;
    logic [15:0] xs [21];
    bit seen;

    rom[0] = 16'sd1; rom[1] = 16'sd2; rom[2] = 16'sd3; rom[3] = 16'sd4;
    repeat (3) @(negedge clk);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", out_data, 32'd0);
    chk("rst_a", 32'(alu_a), 32'd0);
    chk("rst_b", 32'(alu_b), 32'd0);
    chk("rst_op", 32'(alu_op_sel), 32'd0);
    chk("rst_addr", 32'(coef_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    chk("rst_ir", 32'(in_ready), 32'd1);

    // Impulse response, back-to-back handshakes for throughput.
    send(16'd1, 32'd1, 0, 16'd0, "imp0", hs0);
    send(16'd0, 32'd2, 0, 16'd0, "imp1", hs1);
    chk("throughput", 32'(hs1 - hs0), 32'(PERIOD));
    send(16'd0, 32'd3, 0, 16'd0, "imp2", dummy);
    send(16'd0, 32'd4, 0, 16'd0, "imp3", dummy);
    send(16'd0, 32'd0, 0, 16'd0, "imp4", dummy);

    do_reset();
    send(16'd1, 32'd1,  0, 16'd0, "step0", dummy);
    send(16'd1, 32'd3,  0, 16'd0, "step1", dummy);
    send(16'd1, 32'd6,  0, 16'd0, "step2", dummy);
    send(16'd1, 32'd10, 0, 16'd0, "step3", dummy);
    send(16'd1, 32'd10, 0, 16'd0, "step4", dummy);

    rom[0] = -16'sd1; rom[1] = 16'sd2; rom[2] = -16'sd3; rom[3] = 16'sd4;
    do_reset();
    send(-16'sd2, 32'h0000_0002, 0, 16'd0, "sgn0", dummy);
    send(16'sd3,  32'hFFFF_FFF9, 0, 16'd0, "sgn1", dummy);

    for (int i = 0; i < 4; i++) rom[i] = -16'sd32768;
    do_reset();
    send(16'h8000, 32'h4000_0000, 0, 16'd0, "ovf0", dummy);
    send(16'h8000, 32'h8000_0000, 0, 16'd0, "ovf1", dummy);
    send(16'h8000, 32'hC000_0000, 0, 16'd0, "ovf2", dummy);
    send(16'h8000, 32'h0000_0000, 0, 16'd0, "ovf3", dummy);

    // Backpressure with a sample waiting during OUT.
    rom[0] = 16'sd1; rom[1] = 16'sd2; rom[2] = 16'sd3; rom[3] = 16'sd4;
    do_reset();
    send(16'd5, 32'd5, 5, 16'd7, "bp0", hs0);
    send(16'd7, 32'd17, 0, 16'd0, "bp1", dummy);

    // Reset while tap 2 is being issued.
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_sample = 16'd9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_issuing", 32'(alu_op_sel), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_op", 32'(alu_op_sel), 32'd0);
    chk("abort_ir", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out", 32'(seen), 32'd0);
    send(16'd1, 32'd1, 0, 16'd0, "post0", dummy);
    send(16'd0, 32'd2, 0, 16'd0, "post1", dummy);
    send(16'd0, 32'd3, 0, 16'd0, "post2", dummy);
    send(16'd0, 32'd4, 0, 16'd0, "post3", dummy);

    // Random coefficients and samples against the convolution model.
    for (int i = 0; i < 4; i++) rom[i] = 16'($urandom);
    do_reset();
    for (int i = 0; i < 21; i++) xs[i] = 16'($urandom);
    for (int i = 0; i < 20; i++) begin
      int hold;
      hold = (i == 19) ? 0 : int'($urandom_range(0, 2));
      hist.push_back(xs[i]);
      if (hist.size() > int'(TAPS)) void'(hist.pop_front());
      send(xs[i], model_y(), hold, xs[i+1], $sformatf("rnd%0d", i), dummy);
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
